// File: rtl/l2_bus_pkg.sv
// Shared types for the L2 shared-bus controller: bus op codes, snoop responses and FSM states.
package l2_bus_pkg;

  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_RWIM  = 8'h4D;
  localparam logic [7:0] OP_INVAL = 8'h49;

  typedef enum logic [1:0] {
    NOHIT = 2'b00,
    HIT   = 2'b01,
    HITM  = 2'b10,
    RSVD  = 2'b11
  } snoop_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_SNOOP,
    ST_DATA,
    ST_DONE
  } bus_state_e;

  function automatic logic isLegalOp(input logic [7:0] op);
    return (op == OP_READ) || (op == OP_WRITE) || (op == OP_RWIM) || (op == OP_INVAL);
  endfunction

endpackage

// File: rtl/shared_bus_controller_arbiter.sv
// Round-robin requester pick: first active request after lastGrant, wrapping; one-hot, combinational.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] lastGrant,
  output logic [N_REQ-1:0]         pick
);

  localparam int IDX_W = $clog2(N_REQ);

  always_comb begin
    int cand;
    logic [IDX_W-1:0] idx;
    logic found;
    pick  = '0;
    found = 1'b0;
    cand  = 0;
    idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = int'(lastGrant) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      idx = IDX_W'(cand);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_bus_controller.sv
// L2 shared snooping-bus arbiter and transaction sequencer (IDLE->ADDR->SNOOP->DATA->DONE).
// Optional data-phase watchdog enabled by defining BUS_TIMEOUT_EN.
module shared_bus_controller
  import l2_bus_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = 32,
  parameter int SNOOP_LAT = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [8*N_REQ-1:0]      req_op,
  input  logic [ADDR_W*N_REQ-1:0] req_addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        done,
  output logic [1:0]              rsp_snoop,
  output logic                    error,
  output logic [7:0]              bus_op,
  output logic [ADDR_W-1:0]       bus_addr,
  output logic                    bus_op_vld,
  input  logic [1:0]              snoop_in,
  input  logic                    data_ready
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = (SNOOP_LAT > 1) ? $clog2(SNOOP_LAT) : 1;
`ifdef BUS_TIMEOUT_EN
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
`endif

  if (N_REQ < 2 || N_REQ > 8 || SNOOP_LAT < 1 || TIMEOUT < 1) begin : gBadParams
    $error("shared_bus_controller: parameter out of range");
  end

  bus_state_e        state;
  logic [N_REQ-1:0]  pick;
  logic [IDX_W-1:0]  pickIdx;
  logic [IDX_W-1:0]  curIdx;
  logic [IDX_W-1:0]  lastGrant;
  logic [7:0]        selOp;
  logic [ADDR_W-1:0] selAddr;
  logic [7:0]        latOp;
  logic              errFlag;
  logic [CNT_W-1:0]  snoopCnt;
  snoop_e            snoopVal;
`ifdef BUS_TIMEOUT_EN
  logic [TO_W-1:0]   toCnt;
`endif

  rr_arbiter #(.N_REQ(N_REQ)) uArb (
    .req      (req),
    .lastGrant(lastGrant),
    .pick     (pick)
  );

  always_comb begin
    pickIdx = '0;
    selOp   = '0;
    selAddr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick[i]) begin
        pickIdx = IDX_W'(i);
        selOp   = req_op[i*8 +: 8];
        selAddr = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Outputs are registered on entry to each state, so a state's outputs are visible for its whole cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      gnt        <= '0;
      done       <= '0;
      rsp_snoop  <= '0;
      error      <= 1'b0;
      bus_op     <= '0;
      bus_addr   <= '0;
      bus_op_vld <= 1'b0;
      lastGrant  <= IDX_W'(N_REQ - 1);
      curIdx     <= '0;
      errFlag    <= 1'b0;
      snoopCnt   <= '0;
`ifdef BUS_TIMEOUT_EN
      toCnt      <= '0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (|pick) begin
            gnt      <= pick;
            curIdx   <= pickIdx;
            latOp    <= selOp;
            snoopVal <= NOHIT;
            errFlag  <= !isLegalOp(selOp);
            if (isLegalOp(selOp)) begin
              bus_op     <= selOp;
              bus_addr   <= selAddr;
              bus_op_vld <= 1'b1;
            end
            state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          bus_op_vld <= 1'b0;
          if (errFlag) begin
            // Illegal op never reaches the bus; complete straight away with error.
            done      <= gnt;
            gnt       <= '0;
            rsp_snoop <= snoopVal;
            error     <= 1'b1;
            state     <= ST_DONE;
          end else begin
            snoopCnt <= CNT_W'(SNOOP_LAT - 1);
            state    <= ST_SNOOP;
          end
        end
        ST_SNOOP: begin
          if (snoopCnt == '0) begin
            snoopVal <= snoop_e'(snoop_in);
            if (latOp == OP_INVAL) begin
              done      <= gnt;
              gnt       <= '0;
              rsp_snoop <= snoop_in;
              error     <= 1'b0;
              bus_op    <= '0;
              bus_addr  <= '0;
              state     <= ST_DONE;
            end else begin
`ifdef BUS_TIMEOUT_EN
              toCnt <= '0;
`endif
              state <= ST_DATA;
            end
          end else begin
            snoopCnt <= snoopCnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (data_ready) begin
            done      <= gnt;
            gnt       <= '0;
            rsp_snoop <= snoopVal;
            error     <= 1'b0;
            bus_op    <= '0;
            bus_addr  <= '0;
            state     <= ST_DONE;
          end
`ifdef BUS_TIMEOUT_EN
          else if (toCnt == TO_W'(TIMEOUT - 1)) begin
            done      <= gnt;
            gnt       <= '0;
            rsp_snoop <= snoopVal;
            error     <= 1'b1;
            bus_op    <= '0;
            bus_addr  <= '0;
            state     <= ST_DONE;
          end else begin
            toCnt <= toCnt + 1'b1;
          end
`endif
        end
        ST_DONE: begin
          done      <= '0;
          rsp_snoop <= '0;
          error     <= 1'b0;
          lastGrant <= curIdx;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_bus_controller.sv
// Self-checking bench for shared_bus_controller: vector table + scoreboard, round-robin and reset sequences.
module tb_shared_bus_controller;
  import l2_bus_pkg::*;

  localparam int N_REQ     = 4;
  localparam int ADDR_W    = 32;
  localparam int SNOOP_LAT = 2;
`ifdef BUS_TIMEOUT_EN
  localparam int TIMEOUT   = 8;
`else
  localparam int TIMEOUT   = 64;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [N_REQ-1:0]        req = '0;
  logic [8*N_REQ-1:0]      req_op = '0;
  logic [ADDR_W*N_REQ-1:0] req_addr = '0;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        done;
  logic [1:0]              rsp_snoop;
  logic                    error;
  logic [7:0]              bus_op;
  logic [ADDR_W-1:0]       bus_addr;
  logic                    bus_op_vld;
  logic [1:0]              snoop_in = 2'b00;
  logic                    data_ready = 1'b0;

  int nChecks = 0;
  int nFail   = 0;

  shared_bus_controller #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .SNOOP_LAT(SNOOP_LAT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_addr(req_addr),
    .gnt(gnt), .done(done), .rsp_snoop(rsp_snoop), .error(error),
    .bus_op(bus_op), .bus_addr(bus_addr), .bus_op_vld(bus_op_vld),
    .snoop_in(snoop_in), .data_ready(data_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [7:0]  op;
    logic [31:0] addr;
    logic [1:0]  snoop;
    int          drAt;
    int          dropAt;
    int          expLat;
    logic [1:0]  expSnoop;
    logic        expErr;
    int          expVld;
  } vec_t;

  vec_t sb[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N_REQ-1:0] oneHot(input int i);
    logic [N_REQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic checkIdle(input string tag);
    check({tag, "_gnt"}, 64'(gnt), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_busop"}, 64'(bus_op), 64'(0));
    check({tag, "_busaddr"}, 64'(bus_addr), 64'(0));
    check({tag, "_vld"}, 64'(bus_op_vld), 64'(0));
    check({tag, "_err"}, 64'(error), 64'(0));
    check({tag, "_snoop"}, 64'(rsp_snoop), 64'(0));
  endtask

  task automatic setReq(input int idx, input logic [7:0] op, input logic [31:0] addr);
    req_op[idx*8 +: 8]             = op;
    req_addr[idx*ADDR_W +: ADDR_W] = addr;
    req[idx]                       = 1'b1;
  endtask

  // Drive one transaction, push its expectation, then pop and compare when done appears.
  task automatic runVec(input vec_t v, input string tag);
    vec_t e;
    int lat, vldCnt;
    logic got;
    logic [7:0] seenOp;
    logic [31:0] seenAddr;
    data_ready = (v.drAt == 0);
    snoop_in   = v.snoop;
    setReq(v.idx, v.op, v.addr);
    sb.push_back(v);
    lat = 0; vldCnt = 0; got = 1'b0; seenOp = '0; seenAddr = '0;
    for (int c = 1; c <= 200 && !got; c++) begin
      @(posedge clk); #1;
      if (!$onehot0(gnt)) check({tag, "_gnt_onehot"}, 64'(gnt), 64'(oneHot(v.idx)));
      if (bus_op_vld) begin
        vldCnt++;
        seenOp   = bus_op;
        seenAddr = bus_addr;
      end
      if (|done) begin
        got = 1'b1;
        lat = c;
      end
      if (c >= v.drAt) data_ready = 1'b1;
      if (c == v.dropAt) begin
        req[v.idx] = 1'b0;
        req_op[v.idx*8 +: 8] = OP_READ;
      end
    end
    check({tag, "_done_seen"}, 64'(got), 64'(1));
    e = sb.pop_front();
    if (got) begin
      check({tag, "_done"}, 64'(done), 64'(oneHot(e.idx)));
      check({tag, "_latency"}, 64'(lat), 64'(e.expLat));
      check({tag, "_rsp_snoop"}, 64'(rsp_snoop), 64'(e.expSnoop));
      check({tag, "_error"}, 64'(error), 64'(e.expErr));
      check({tag, "_gnt_at_done"}, 64'(gnt), 64'(0));
    end
    check({tag, "_vld_count"}, 64'(vldCnt), 64'(e.expVld));
    if (e.expVld == 1) begin
      check({tag, "_bus_op"}, 64'(seenOp), 64'(e.op));
      check({tag, "_bus_addr"}, 64'(seenAddr), 64'(e.addr));
    end
    req[v.idx] = 1'b0;
    data_ready = 1'b0;
    @(posedge clk); #1;
    checkIdle({tag, "_after"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rrQ[$];
    int prevDone;
    int anyDone;
    vec_t tv;

    vecs[0] = '{idx:0, op:OP_READ,  addr:32'h0000_1040, snoop:2'b00, drAt:0,    dropAt:0, expLat:5,  expSnoop:2'b00, expErr:1'b0, expVld:1};
    vecs[1] = '{idx:2, op:OP_INVAL, addr:32'h0000_2000, snoop:2'b01, drAt:1000, dropAt:0, expLat:4,  expSnoop:2'b01, expErr:1'b0, expVld:1};
    vecs[2] = '{idx:1, op:OP_RWIM,  addr:32'h0000_3000, snoop:2'b10, drAt:10,   dropAt:0, expLat:11, expSnoop:2'b10, expErr:1'b0, expVld:1};
    vecs[3] = '{idx:3, op:8'h58,    addr:32'h0000_4000, snoop:2'b00, drAt:0,    dropAt:0, expLat:2,  expSnoop:2'b00, expErr:1'b1, expVld:0};
    vecs[4] = '{idx:0, op:OP_WRITE, addr:32'h0000_5000, snoop:2'b11, drAt:0,    dropAt:0, expLat:5,  expSnoop:2'b11, expErr:1'b0, expVld:1};
    vecs[5] = '{idx:2, op:OP_READ,  addr:32'h0000_6000, snoop:2'b01, drAt:6,    dropAt:0, expLat:7,  expSnoop:2'b01, expErr:1'b0, expVld:1};
    vecs[6] = '{idx:2, op:OP_READ,  addr:32'h0000_6040, snoop:2'b00, drAt:0,    dropAt:0, expLat:5,  expSnoop:2'b00, expErr:1'b0, expVld:1};
    vecs[7] = '{idx:1, op:OP_WRITE, addr:32'h0000_7000, snoop:2'b00, drAt:0,    dropAt:2, expLat:5,  expSnoop:2'b00, expErr:1'b0, expVld:1};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkIdle("reset");
    rst_n = 1'b1;

    // All four requesting from reset: grants must rotate 0,1,2,3,0.
    for (int i = 0; i < N_REQ; i++) setReq(i, OP_READ, 32'h100 * (i + 1));
    data_ready = 1'b1;
    snoop_in   = 2'b00;
    rrQ = '{0, 1, 2, 3, 0};
    prevDone = -1;
    for (int c = 1; c <= 100 && rrQ.size() > 0; c++) begin
      @(posedge clk); #1;
      check("rr_gnt_onehot", 64'($onehot0(gnt)), 64'(1));
      if (bus_op_vld) check("rr_bus_addr", 64'(bus_addr), 64'(32'h100 * (rrQ[0] + 1)));
      if (|done) begin
        check("rr_done_order", 64'(done), 64'(oneHot(rrQ.pop_front())));
        if (prevDone >= 0) check("rr_done_spacing", 64'(c - prevDone), 64'(6));
        prevDone = c;
        if (rrQ.size() == 0) req = '0;
      end
    end
    check("rr_all_done", 64'(rrQ.size()), 64'(0));
    req = '0;
    data_ready = 1'b0;
    @(posedge clk); #1;
    checkIdle("rr_after");

    for (int i = 0; i < 8; i++) runVec(vecs[i], $sformatf("vec%0d", i));

`ifdef BUS_TIMEOUT_EN
    tv = '{idx:3, op:OP_READ, addr:32'h0000_8000, snoop:2'b10, drAt:1000, dropAt:0, expLat:4 + TIMEOUT, expSnoop:2'b10, expErr:1'b1, expVld:1};
    runVec(tv, "timeout");
`else
    tv = '{idx:3, op:OP_READ, addr:32'h0000_8000, snoop:2'b10, drAt:70, dropAt:0, expLat:71, expSnoop:2'b10, expErr:1'b0, expVld:1};
    runVec(tv, "long_wait");
`endif

    // Abort a transaction in DATA with reset; no done may follow.
    snoop_in = 2'b00;
    data_ready = 1'b0;
    setReq(1, OP_READ, 32'h0000_9000);
    repeat (4) @(posedge clk);
    #1;
    check("abort_in_data_gnt", 64'(gnt), 64'(oneHot(1)));
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkIdle("abort_reset");
    rst_n = 1'b1;
    req = '0;
    anyDone = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (|done) anyDone++;
    end
    check("abort_no_done", 64'(anyDone), 64'(0));

    // After reset requester 0 must win over 1 even though 1 was granted before.
    req[1] = 1'b1;
    tv = '{idx:0, op:OP_READ, addr:32'h0000_A000, snoop:2'b00, drAt:0, dropAt:0, expLat:5, expSnoop:2'b00, expErr:1'b0, expVld:1};
    runVec(tv, "post_reset_prio0");
    tv = '{idx:1, op:OP_READ, addr:32'h0000_9000, snoop:2'b00, drAt:0, dropAt:0, expLat:5, expSnoop:2'b00, expErr:1'b0, expVld:1};
    runVec(tv, "post_reset_prio1");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
